// File: rtl/divrem_arb_if.sv
// Divider-side bus of the divrem arbiter.
// The arbiter holds the master modport: it drives go/num/den and observes
// ready/error/quot/rem. The divider instance holds the slave modport.
interface divrem_arb_if #(
    parameter int WIDTH = 16
);
    logic             div_go;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic             div_ready;
    logic             div_error;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    modport master (
        output div_go,
        output div_num,
        output div_den,
        input  div_ready,
        input  div_error,
        input  div_quot,
        input  div_rem
    );

    modport slave (
        input  div_go,
        input  div_num,
        input  div_den,
        output div_ready,
        output div_error,
        output div_quot,
        output div_rem
    );
endinterface

// File: rtl/divrem_arb.sv
// Round-robin scheduler sharing one divrem divider between NREQ requesters.
// A winner's operands are latched and held on the divider bus for the whole
// transaction, so requesters may change their inputs as soon as gnt is seen.
// Results come back with a one-cycle done pulse and then hold until the next
// completion. Only one division is ever outstanding.
module divrem_arb #(
    parameter int NREQ      = 4,
    parameter int WIDTH_LOG = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ*(1 << WIDTH_LOG)-1:0]    num,
    input  logic [NREQ*(1 << WIDTH_LOG)-1:0]    den,
    output logic [NREQ-1:0]                     gnt,
    output logic [NREQ-1:0]                     done,
    output logic [(1 << WIDTH_LOG)-1:0]         res_quot,
    output logic [(1 << WIDTH_LOG)-1:0]         res_rem,
    output logic                                res_error,
    output logic                                busy,
    divrem_arb_if.master                        div
);

    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IW-1:0]    last;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic             win_found;
    logic             start_txn;
    logic             finish_txn;
    logic [WIDTH-1:0] num_arr [NREQ];
    logic [WIDTH-1:0] den_arr [NREQ];

    // Unpack the per-requester operand slices so they can be picked by index.
    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign num_arr[g] = num[g*WIDTH +: WIDTH];
            assign den_arr[g] = den[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: scan downward so the nearest requester after 'last' wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the start/finish strobes that steer the datapath.
    always_comb begin
        state_next = state;
        start_txn  = 1'b0;
        finish_txn = 1'b0;
        case (state)
            ST_IDLE: begin
                // A divider still busy from before an arbiter-only reset
                // keeps ready low, so it is never handed a second go.
                if (win_found && div.div_ready) begin
                    start_txn  = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (div.div_ready) begin
                    finish_txn = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign div.div_go = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);

    // Operand latch, grant/done pulses and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last        <= LAST_RST;
            owner       <= '0;
            gnt         <= '0;
            done        <= '0;
            res_quot    <= '0;
            res_rem     <= '0;
            res_error   <= 1'b0;
            div.div_num <= '0;
            div.div_den <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (start_txn) begin
                div.div_num <= num_arr[win_idx];
                div.div_den <= den_arr[win_idx];
                owner       <= win_idx;
                last        <= win_idx;
                gnt         <= ONE_HOT0 << win_idx;
            end
            if (finish_txn) begin
                done      <= ONE_HOT0 << owner;
                res_error <= div.div_error;
                // The divider's quot/rem are meaningless on divide-by-zero.
                res_quot  <= div.div_error ? '0 : div.div_quot;
                res_rem   <= div.div_error ? '0 : div.div_rem;
            end
        end
    end

endmodule

// File: tb/tb_divrem_arb.sv
// Self-checking bench for divrem_arb with a behavioural divider stand-in.
// A transaction-level model predicts gnt/done/results every cycle; directed
// tasks add hand-computed literal expectations for the key scenarios.
module tb_divrem_arb;

    localparam int NREQ      = 4;
    localparam int WIDTH_LOG = 4;
    localparam int WIDTH     = 1 << WIDTH_LOG;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic [NREQ-1:0]         req   = '0;
    logic [NREQ*WIDTH-1:0]   num   = '0;
    logic [NREQ*WIDTH-1:0]   den   = '0;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [WIDTH-1:0]        res_quot;
    logic [WIDTH-1:0]        res_rem;
    logic                    res_error;
    logic                    busy;
    logic                    hold_busy = 1'b0;

    int passed = 0;
    int total  = 0;

    divrem_arb_if #(.WIDTH(WIDTH)) dbus ();

    divrem_arb #(
        .NREQ      (NREQ),
        .WIDTH_LOG (WIDTH_LOG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .num       (num),
        .den       (den),
        .gnt       (gnt),
        .done      (done),
        .res_quot  (res_quot),
        .res_rem   (res_rem),
        .res_error (res_error),
        .busy      (busy),
        .div       (dbus)
    );

    always #5 clk = ~clk;

    // Divider stand-in: ready is registered on the go edge; trivial cases
    // (den==0, num<den) keep ready high, others drop it for a few cycles.
    // Divide-by-zero returns garbage quot/rem to expose missing forcing.
    logic             dv_ready = 1'b1;
    logic             dv_error = 1'b0;
    logic [WIDTH-1:0] dv_quot  = '0;
    logic [WIDTH-1:0] dv_rem   = '0;
    int               dv_cnt   = 0;

    assign dbus.div_ready = dv_ready;
    assign dbus.div_error = dv_error;
    assign dbus.div_quot  = dv_quot;
    assign dbus.div_rem   = dv_rem;

    // Divider behaviour, clocked like the real instance.
    always @(posedge clk) begin
        if (hold_busy) begin
            dv_ready <= 1'b0;
            dv_cnt   <= 1;
        end else if (dbus.div_go) begin
            if (dbus.div_den == '0) begin
                dv_ready <= 1'b1;
                dv_error <= 1'b1;
                dv_quot  <= 16'hDEAD;
                dv_rem   <= 16'hBEEF;
            end else if (dbus.div_num < dbus.div_den) begin
                dv_ready <= 1'b1;
                dv_error <= 1'b0;
                dv_quot  <= '0;
                dv_rem   <= dbus.div_num;
            end else begin
                dv_ready <= 1'b0;
                dv_error <= 1'b0;
                dv_cnt   <= 3;
            end
        end else if (!dv_ready) begin
            if (dv_cnt > 1) begin
                dv_cnt <= dv_cnt - 1;
            end else begin
                dv_ready <= 1'b1;
                dv_error <= 1'b0;
                if (dbus.div_den != '0) begin
                    dv_quot <= dbus.div_num / dbus.div_den;
                    dv_rem  <= dbus.div_num % dbus.div_den;
                end else begin
                    dv_quot <= '0;
                    dv_rem  <= '0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        $display("[TB] FAIL %s: got no response within the cycle bound, expected one at %0t", name, $time);
    endtask

    function automatic int rrWinner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] sliceOf(input logic [NREQ*WIDTH-1:0] v, input int i);
        return WIDTH'(v >> (i * WIDTH));
    endfunction

    function automatic int ohIndex(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Transaction-level model and per-cycle compare, sampled on the falling edge.
    initial begin
        bit               m_out;
        int               m_age, m_last, m_owner, w;
        logic [WIDTH-1:0] m_num, m_den, h_q, h_r;
        logic             h_e;
        logic [NREQ-1:0]  exp_gnt, exp_done, p_req;
        logic [NREQ*WIDTH-1:0] p_num, p_den;
        logic             p_ready;
        bit               p_ok;
        m_out = 0; m_age = 0; m_last = NREQ - 1; m_owner = 0;
        m_num = '0; m_den = '0; h_q = '0; h_r = '0; h_e = 1'b0;
        p_req = '0; p_num = '0; p_den = '0; p_ready = 1'b0; p_ok = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_ctrl", {gnt, done, busy, dbus.div_go, res_error}, '0);
                checkOutput("rst_res", {res_quot, res_rem}, '0);
                checkOutput("rst_div_bus", {dbus.div_num, dbus.div_den}, '0);
                m_out = 0; m_last = NREQ - 1;
                h_q = '0; h_r = '0; h_e = 1'b0;
                p_ok = 0;
            end else begin
                exp_gnt  = '0;
                exp_done = '0;
                if (m_out) begin
                    if (m_age >= 1 && p_ready) begin
                        exp_done = NREQ'(1 << m_owner);
                        m_out    = 0;
                        if (m_den == '0) begin
                            h_q = '0; h_r = '0; h_e = 1'b1;
                        end else begin
                            h_q = m_num / m_den; h_r = m_num % m_den; h_e = 1'b0;
                        end
                    end else begin
                        m_age++;
                    end
                end else if (p_ok && p_req != '0 && p_ready) begin
                    w       = rrWinner(p_req, m_last);
                    exp_gnt = NREQ'(1 << w);
                    m_last  = w;
                    m_owner = w;
                    m_num   = sliceOf(p_num, w);
                    m_den   = sliceOf(p_den, w);
                    m_out   = 1;
                    m_age   = 0;
                end
                checkOutput("gnt", gnt, exp_gnt);
                checkOutput("done", done, exp_done);
                checkOutput("div_go", dbus.div_go, exp_gnt != '0);
                checkOutput("busy", busy, m_out);
                checkOutput("res_quot_rem", {res_quot, res_rem}, {h_q, h_r});
                checkOutput("res_error", res_error, h_e);
                if (m_out) checkOutput("div_operands", {dbus.div_num, dbus.div_den}, {m_num, m_den});
                p_ok = 1;
            end
            p_req   = req;
            p_num   = num;
            p_den   = den;
            p_ready = dbus.div_ready;
        end
    end

    task automatic setOperands(input int i, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        num[i*WIDTH +: WIDTH] = n;
        den[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic applyStimulus(input int i, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        setOperands(i, n, d);
        req[i] = 1'b1;
    endtask

    // One request from idle: literal result, grant cycle and done latency.
    task automatic runOne(input string name, input int i,
                          input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic ee, input int elat, input bit garble);
        int gc, dc;
        gc = -1;
        dc = -1;
        @(posedge clk); #1;
        applyStimulus(i, n, d);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt[i] && gc < 0) gc = c;
            if (done[i]) begin
                dc = c;
                checkOutput({name, "_quot"}, res_quot, eq);
                checkOutput({name, "_rem"}, res_rem, er);
                checkOutput({name, "_err"}, res_error, ee);
                checkOutput({name, "_latency"}, dc, elat);
                break;
            end
            @(posedge clk); #1;
            if (gc >= 0 && req[i]) begin
                req[i] = 1'b0;
                if (garble) setOperands(i, 16'h0001, 16'h0000);
            end
        end
        if (gc < 0 || dc < 0) reportTimeout(name);
        else checkOutput({name, "_gnt_cycle"}, gc, 1);
    endtask

    // Directed sequence.
    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [WIDTH-1:0] tq [NREQ] = '{16'd14, 16'd22, 16'd0, 16'd0};
        logic [WIDTH-1:0] tr [NREQ] = '{16'd2, 16'd2, 16'd50, 16'd0};
        logic             te [NREQ] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int gcount, dcount, j, gc;
        bit seen0, seen2;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin with all four requests held high.
        @(posedge clk); #1;
        applyStimulus(0, 16'd100, 16'd7);
        applyStimulus(1, 16'd200, 16'd9);
        applyStimulus(2, 16'd50, 16'd60);
        applyStimulus(3, 16'd1000, 16'd0);
        gcount = 0;
        dcount = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (gcount < 5) checkOutput("rr_order", ohIndex(gnt), order[gcount]);
                else checkOutput("rr_extra_gnt", gnt, '0);
                gcount++;
            end
            if (done != '0) begin
                j = ohIndex(done);
                checkOutput("rr_quot", res_quot, tq[j]);
                checkOutput("rr_rem", res_rem, tr[j]);
                checkOutput("rr_err", res_error, te[j]);
                dcount++;
            end
            if (dcount >= 5) break;
            @(posedge clk); #1;
            if (gcount >= 5) req = '0;
        end
        if (dcount < 5) reportTimeout("rr_five_done");
        req = '0;

        runOne("single_100_7", 0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 6, 0);
        runOne("divzero_55_0", 2, 16'd55, 16'd0, 16'd0, 16'd0, 1'b1, 3, 0);
        runOne("stable_ffff_3", 1, 16'hFFFF, 16'h0003, 16'h5555, 16'h0000, 1'b0, 6, 1);
        runOne("bound_5_9", 3, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 3, 0);
        runOne("bound_ffff_1", 0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 6, 0);
        runOne("bound_9_9", 1, 16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 6, 0);

        // Reset in the middle of a division.
        @(posedge clk); #1;
        applyStimulus(2, 16'd1000, 16'd7);
        gc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt[2]) begin gc = c; break; end
        end
        if (gc < 0) reportTimeout("midrst_gnt");
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #2;
        hold_busy = 1'b1;
        rst_n     = 1'b0;
        #1;
        checkOutput("midrst_ctrl", {gnt, done, busy, dbus.div_go, res_error}, '0);
        checkOutput("midrst_res", {res_quot, res_rem}, '0);
        checkOutput("midrst_div_bus", {dbus.div_num, dbus.div_den}, '0);
        applyStimulus(0, 16'd77, 16'd7);
        applyStimulus(2, 16'd30, 16'd4);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("busy_divider_no_gnt", gnt, '0);
        end
        @(posedge clk); #1;
        hold_busy = 1'b0;
        gcount = 0;
        seen0  = 0;
        seen2  = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (gcount == 0) checkOutput("post_rst_first_gnt", gnt, 4'b0001);
                gcount++;
            end
            if (done[0]) begin
                seen0 = 1;
                checkOutput("post_rst_r0", {res_quot, res_rem}, {16'd11, 16'd0});
            end
            if (done[2]) begin
                seen2 = 1;
                checkOutput("post_rst_r2", {res_quot, res_rem}, {16'd7, 16'd2});
            end
            if (seen0 && seen2) break;
            @(posedge clk); #1;
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[2]) req[2] = 1'b0;
        end
        if (!(seen0 && seen2)) reportTimeout("post_rst_done");
        req = '0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/divrem_arb.md
# divrem_arb

Round-robin scheduler that shares one `divrem` divider instance between `NREQ` requesters. It accepts a request from one requester, latches its operands and drives the divider's `go`/`num`/`den`, holding them until the divider reports `ready`. It then returns quotient, remainder and error to that requester with a one-cycle `done` pulse. It sits between the divider and the clients that need division, such as the sieve and the output formatter.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH_LOG`, default 4: operand width is `WIDTH = 1 << WIDTH_LOG`; must match the divider instance.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req` input, `NREQ` bits: request per requester; held high with operands stable until its `gnt` bit is seen.
- `num` input, `NREQ*WIDTH` bits: packed dividends; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `den` input, `NREQ*WIDTH` bits: packed divisors, same packing as `num`.
- `gnt` output, `NREQ` bits: one-hot, one-cycle pulse; operands were latched.
- `done` output, `NREQ` bits: one-hot, one-cycle pulse; results valid this cycle.
- `res_quot` output, `WIDTH` bits: quotient, valid while `done` is non-zero.
- `res_rem` output, `WIDTH` bits: remainder, valid while `done` is non-zero.
- `res_error` output, 1 bit: divide-by-zero flag, valid while `done` is non-zero.
- `busy` output, 1 bit: high in ISSUE and WAIT.
- `div_go` output, 1 bit: connects to the divider's `go`.
- `div_num` output, `WIDTH` bits: connects to the divider's `num`.
- `div_den` output, `WIDTH` bits: connects to the divider's `den`.
- `div_ready` input, 1 bit: from the divider's `ready`.
- `div_error` input, 1 bit: from the divider's `error`.
- `div_quot` input, `WIDTH` bits: from the divider's `quot`.
- `div_rem` input, `WIDTH` bits: from the divider's `rem`.

## Operation
- **Reset values.** While `rst_n` is low: state IDLE, `last` = `NREQ-1`, and `gnt`, `done`, `res_*`, `div_go`, `div_num`, `div_den` and `busy` are all 0. Reset mid-operation abandons the transaction; no `done` is produced.
- **IDLE.**
  - Arbitrate only when `req != 0` and `div_ready == 1`. This covers a divider that is still busy after an arbiter-only reset.
  - The winner is the first set `req` bit searching upward from `last+1`, wrapping modulo `NREQ`.
  - On the edge: latch `num`/`den` of the winner into `div_num`/`div_den`, set `owner` and `last` to the winner, register `gnt` = onehot(winner), and go to ISSUE.
- **ISSUE.**
  - `div_go` = 1 for exactly this cycle; `gnt` is high for this cycle.
  - Go to WAIT unconditionally. `req` is ignored.
- **WAIT.**
  - `div_num`/`div_den` stay stable; the divider reads `den` every cycle.
  - When `div_ready == 1`: register `res_quot`/`res_rem`/`res_error` and `done` = onehot(`owner`), then go to IDLE.
  - If `div_error == 1`, `res_quot` and `res_rem` are forced to 0, not passed through.
- `div_ready` is valid in WAIT because the divider registers `ready` on the edge that samples `go`. On divide-by-zero `ready` never falls, so the first WAIT cycle already completes.
- `done` and `res_*` are high or valid for one cycle, then `done` returns to 0. `res_*` hold their values until the next `done`.
- `div_go` is never asserted outside ISSUE. Only one transaction is ever outstanding.
- A requester that keeps `req` high after its `gnt` posts a new request. It competes in the next IDLE cycle; round-robin prevents starvation.

## Timing
- Cycle 0 (IDLE): `req` sampled.
- Cycle 1 (ISSUE): `gnt` and `div_go` high.
- Cycle 2 onward (WAIT): waiting on `div_ready`.
- If `div_ready` is seen in cycle k, `done` is high in cycle k+1, state is IDLE in cycle k+1, and the next `gnt` can be in cycle k+2.
- Minimum `req`→`done` latency is 3 cycles (divide-by-zero, or `num < den`).
- Throughput: one division per (divider time + 3) cycles.
- Simultaneous `req` bits: exactly one `gnt` per arbitration; the others wait with `req` held.

## Test plan
- **Single request.** Requester 0 sends 100/7 → `gnt[0]` in cycle 1, `div_go` for 1 cycle, `done[0]` with `res_quot`=14, `res_rem`=2, `res_error`=0.
- **Divide by zero.** Requester 2 sends 55/0 → `done[2]` in cycle 3 with `res_error`=1, `res_quot`=0, `res_rem`=0.
- **Round-robin.** All 4 `req` held high with distinct operands → grant order 0,1,2,3,0. Each `done` carries that requester's correct quotient and remainder. No `gnt` while `busy`.
- **Operand stability.** Requester 1 changes `num`/`den` to garbage right after `gnt[1]` for 0xFFFF/0x0003 → result is still 0x5555/0.
- **Boundaries.**
  - 5/9 gives 0/5.
  - 0xFFFF/1 gives 0xFFFF/0.
  - 9/9 gives 1/0.
- **Reset mid-operation.** Pull `rst_n` low during WAIT → all outputs are 0 immediately with no `done`. After release, no `gnt` until `div_ready`=1; the next grant goes to requester 0 first.
